// File: rtl/snoopy_bus_controller_pkg.sv
// Shared definitions for the snoopy bus controller: bus command encoding,
// controller states and the invalidating-command classifier.
package snoopy_bus_controller_pkg;

    localparam int COMMAND_WIDTH = 2;

    typedef enum logic [COMMAND_WIDTH-1:0] {
        NONE               = 2'd0,
        BUS_READ           = 2'd1,
        BUS_READ_EXCLUSIVE = 2'd2,
        BUS_INVALIDATE     = 2'd3
    } command_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Commands that oblige every other cache to drop its copy of the line.
    function automatic logic isInvalidating(input command_t command);
        return (command == BUS_INVALIDATE) || (command == BUS_READ_EXCLUSIVE);
    endfunction

endpackage

// File: rtl/snoopy_bus_controller_round_robin_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// the pointer, wrapping modulo NUMBER_OF_CACHES.
module round_robin_arbiter #(
    parameter int NUMBER_OF_CACHES = 4,
    parameter int INDEX_WIDTH      = 2
) (
    input  logic [NUMBER_OF_CACHES-1:0] request,
    input  logic [INDEX_WIDTH-1:0]      pointer,
    output logic [NUMBER_OF_CACHES-1:0] grant,
    output logic [INDEX_WIDTH-1:0]      grant_index
);

    logic [INDEX_WIDTH-1:0] candidate;
    logic                   found;

    always_comb begin
        grant       = '0;
        grant_index = '0;
        found       = 1'b0;
        candidate   = '0;
        for (int i = 0; i < NUMBER_OF_CACHES; i++) begin
            candidate = INDEX_WIDTH'((int'(pointer) + i) % NUMBER_OF_CACHES);
            if (!found && request[candidate]) begin
                found            = 1'b1;
                grant[candidate] = 1'b1;
                grant_index      = candidate;
            end
        end
    end

endmodule

// File: rtl/snoopy_bus_controller.sv
// Bus side of the snoopy invalidate protocol: grants one owner at a time,
// broadcasts its command/address and collects the snoopers' acknowledgements.
// Optional invalidate-collection watchdog enabled by SNOOPY_BUS_TIMEOUT_EN.
module snoopy_bus_controller
    import snoopy_bus_controller_pkg::*;
#(
    parameter int NUMBER_OF_CACHES = 4,
    parameter int ADDRESS_WIDTH    = 16
`ifdef SNOOPY_BUS_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUMBER_OF_CACHES-1:0]           request,
    output logic [NUMBER_OF_CACHES-1:0]           grant,
    input  logic [NUMBER_OF_CACHES*COMMAND_WIDTH-1:0] cpuCommandOut,
    input  logic [NUMBER_OF_CACHES*ADDRESS_WIDTH-1:0] cpuAddress,
    output logic [NUMBER_OF_CACHES-1:0]           cpuIsInvalidated,
    output logic [NUMBER_OF_CACHES*COMMAND_WIDTH-1:0] snoopyCommandIn,
    output logic [ADDRESS_WIDTH-1:0]              snoopyAddress,
    input  logic [NUMBER_OF_CACHES-1:0]           snoopyIsInvalidated
`ifdef SNOOPY_BUS_TIMEOUT_EN
    , output logic                                timeoutError
`endif
);

    localparam int INDEX_WIDTH = (NUMBER_OF_CACHES > 1) ? $clog2(NUMBER_OF_CACHES) : 1;

    state_t                               state_q, state_d;
    logic [NUMBER_OF_CACHES-1:0]          grant_q, grant_d;
    logic [INDEX_WIDTH-1:0]               owner_q, owner_d;
    logic [INDEX_WIDTH-1:0]               pointer_q, pointer_d;
    logic [NUMBER_OF_CACHES*COMMAND_WIDTH-1:0] snoop_cmd_q, snoop_cmd_d;
    command_t                             bcast_cmd_q, bcast_cmd_d;
    logic [ADDRESS_WIDTH-1:0]             snoop_addr_q, snoop_addr_d;
    logic [NUMBER_OF_CACHES-1:0]          ack_q, ack_d;
    logic [NUMBER_OF_CACHES-1:0]          cpu_inv_q, cpu_inv_d;

    logic [NUMBER_OF_CACHES-1:0]          arb_grant;
    logic [INDEX_WIDTH-1:0]               arb_index;
    command_t                             owner_cmd;
    logic [ADDRESS_WIDTH-1:0]             owner_addr;

`ifdef SNOOPY_BUS_TIMEOUT_EN
    localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   timeout_error_q, timeout_error_d;
`endif

    round_robin_arbiter #(
        .NUMBER_OF_CACHES (NUMBER_OF_CACHES),
        .INDEX_WIDTH      (INDEX_WIDTH)
    ) u_arbiter (
        .request     (request),
        .pointer     (pointer_q),
        .grant       (arb_grant),
        .grant_index (arb_index)
    );

    assign owner_cmd  = command_t'(cpuCommandOut[int'(owner_q)*COMMAND_WIDTH +: COMMAND_WIDTH]);
    assign owner_addr = cpuAddress[int'(owner_q)*ADDRESS_WIDTH +: ADDRESS_WIDTH];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        pointer_d    = pointer_q;
        snoop_cmd_d  = snoop_cmd_q;
        bcast_cmd_d  = bcast_cmd_q;
        snoop_addr_d = snoop_addr_q;
        ack_d        = ack_q;
        cpu_inv_d    = cpu_inv_q;
`ifdef SNOOPY_BUS_TIMEOUT_EN
        timer_d         = timer_q;
        timeout_error_d = timeout_error_q;
`endif
        unique case (state_q)
            IDLE: begin
                snoop_cmd_d = '0;
                bcast_cmd_d = NONE;
                ack_d       = '0;
                cpu_inv_d   = '0;
`ifdef SNOOPY_BUS_TIMEOUT_EN
                timer_d     = '0;
`endif
                if (|request) begin
                    grant_d = arb_grant;
                    owner_d = arb_index;
                    state_d = GRANTED;
                end
            end
            GRANTED: begin
                if (!request[owner_q]) begin
                    state_d     = RELEASE;
                    grant_d     = '0;
                    snoop_cmd_d = '0;
                    bcast_cmd_d = NONE;
                    ack_d       = '0;
                    cpu_inv_d   = '0;
`ifdef SNOOPY_BUS_TIMEOUT_EN
                    timer_d     = '0;
`endif
                end else begin
                    bcast_cmd_d  = owner_cmd;
                    snoop_addr_d = owner_addr;
                    for (int i = 0; i < NUMBER_OF_CACHES; i++) begin
                        snoop_cmd_d[i*COMMAND_WIDTH +: COMMAND_WIDTH] =
                            (i == int'(owner_q)) ? NONE : owner_cmd;
                    end
                    // A new command restarts collection; responses seen this
                    // cycle belong to the old broadcast and are dropped.
                    if (owner_cmd != bcast_cmd_q) begin
                        ack_d     = '0;
                        cpu_inv_d = '0;
`ifdef SNOOPY_BUS_TIMEOUT_EN
                        timer_d   = '0;
`endif
                    end else if (isInvalidating(bcast_cmd_q)) begin
                        ack_d = ack_q | (snoopyIsInvalidated & ~grant_q);
                        if (&(ack_d | grant_q)) begin
                            cpu_inv_d[owner_q] = 1'b1;
                        end
`ifdef SNOOPY_BUS_TIMEOUT_EN
                        if (!cpu_inv_q[owner_q]) begin
                            if (timer_q == TIMER_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                                cpu_inv_d[owner_q] = 1'b1;
                                timeout_error_d    = 1'b1;
                            end else begin
                                timer_d = timer_q + 1'b1;
                            end
                        end
`endif
                    end
                end
            end
            RELEASE: begin
                pointer_d = INDEX_WIDTH'((int'(owner_q) + 1) % NUMBER_OF_CACHES);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            pointer_q    <= '0;
            snoop_cmd_q  <= '0;
            bcast_cmd_q  <= NONE;
            snoop_addr_q <= '0;
            ack_q        <= '0;
            cpu_inv_q    <= '0;
`ifdef SNOOPY_BUS_TIMEOUT_EN
            timer_q         <= '0;
            timeout_error_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            pointer_q    <= pointer_d;
            snoop_cmd_q  <= snoop_cmd_d;
            bcast_cmd_q  <= bcast_cmd_d;
            snoop_addr_q <= snoop_addr_d;
            ack_q        <= ack_d;
            cpu_inv_q    <= cpu_inv_d;
`ifdef SNOOPY_BUS_TIMEOUT_EN
            timer_q         <= timer_d;
            timeout_error_q <= timeout_error_d;
`endif
        end
    end

    assign grant            = grant_q;
    assign cpuIsInvalidated = cpu_inv_q;
    assign snoopyCommandIn  = snoop_cmd_q;
    assign snoopyAddress    = snoop_addr_q;
`ifdef SNOOPY_BUS_TIMEOUT_EN
    assign timeoutError     = timeout_error_q;
`endif

endmodule

// File: tb/tb_snoopy_bus_controller.sv
// Self-checking bench for snoopy_bus_controller: directed scenarios plus a
// randomized run compared against a transaction-level model of the bus.
module tb_snoopy_bus_controller;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam logic [1:0] C_NONE = 2'd0, C_READ = 2'd1, C_RDX = 2'd2, C_INV = 2'd3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  request = '0;
    logic [N*2-1:0]  cpuCommandOut = '0;
    logic [N*AW-1:0] cpuAddress = '0;
    logic [N-1:0]  snoopyIsInvalidated = '0;
    logic [N-1:0]  grant;
    logic [N-1:0]  cpuIsInvalidated;
    logic [N*2-1:0] snoopyCommandIn;
    logic [AW-1:0] snoopyAddress;
`ifdef SNOOPY_BUS_TIMEOUT_EN
    logic          timeoutError;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    snoopy_bus_controller #(
        .NUMBER_OF_CACHES (N),
        .ADDRESS_WIDTH    (AW)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .request             (request),
        .grant               (grant),
        .cpuCommandOut       (cpuCommandOut),
        .cpuAddress          (cpuAddress),
        .cpuIsInvalidated    (cpuIsInvalidated),
        .snoopyCommandIn     (snoopyCommandIn),
        .snoopyAddress       (snoopyAddress),
`ifdef SNOOPY_BUS_TIMEOUT_EN
        .timeoutError        (timeoutError),
`endif
        .snoopyIsInvalidated (snoopyIsInvalidated)
    );

    // Reference model: who owns the bus, what it last broadcast, which
    // snoopers have answered and whether the owner has been acknowledged.
    int         m_owner = -1;
    bit         m_rel   = 1'b0;
    int         m_ptr   = 0;
    logic [1:0] m_cmd   = C_NONE;
    logic [N-1:0] m_ack = '0;
    bit         m_done  = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [1:0] new_cmd;

    always @(posedge clock) begin
        if (reset) begin
            m_owner = -1; m_rel = 1'b0; m_ptr = 0; m_cmd = C_NONE;
            m_ack = '0; m_done = 1'b0; m_addr = '0;
        end else if (m_rel) begin
            m_ptr = (m_owner + 1) % N;
            m_owner = -1;
            m_rel = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++)
                if (m_owner < 0 && request[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        end else if (!request[m_owner]) begin
            m_rel = 1'b1; m_cmd = C_NONE; m_ack = '0; m_done = 1'b0;
        end else begin
            new_cmd = cpuCommandOut[m_owner*2 +: 2];
            m_addr  = cpuAddress[m_owner*AW +: AW];
            if (new_cmd != m_cmd) begin
                m_cmd = new_cmd; m_ack = '0; m_done = 1'b0;
            end else if (m_cmd == C_RDX || m_cmd == C_INV) begin
                for (int k = 0; k < N; k++)
                    if (k != m_owner && snoopyIsInvalidated[k]) m_ack[k] = 1'b1;
                if ($countones(m_ack) == N - 1) m_done = 1'b1;
            end
        end
    end

    task automatic set_cmd(input int c, input logic [1:0] cmd, input logic [AW-1:0] addr);
        cpuCommandOut[c*2 +: 2] = cmd;
        cpuAddress[c*AW +: AW]  = addr;
    endtask

    task automatic test_reset();
        reset = 1'b1; request = '0;
        @(negedge clock); @(negedge clock);
        n_checks++; if (grant !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_grant: got %b expected 0000", grant); end
        n_checks++; if (cpuIsInvalidated !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_cpuinv: got %b expected 0000", cpuIsInvalidated); end
        n_checks++; if (snoopyCommandIn !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_snoopcmd: got %h expected 00", snoopyCommandIn); end
        n_checks++; if (snoopyAddress !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h expected 0000", snoopyAddress); end
        reset = 1'b0;
        @(negedge clock);
        n_checks++; if (grant !== 4'b0) begin n_fail++; $display("[TB] FAIL idle_grant: got %b expected 0000", grant); end
    endtask

    task automatic test_grant_and_invalidate();
        request = 4'b0010;
        set_cmd(0, C_READ, 16'h0aaa); set_cmd(1, C_NONE, 16'h0000); set_cmd(2, C_INV, 16'h0bbb);
        @(negedge clock);
        n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("[TB] FAIL first_grant: got %b expected 0010", grant); end
        n_checks++; if (snoopyCommandIn !== 8'h00) begin n_fail++; $display("[TB] FAIL pre_cmd_none0: got %h expected 00", snoopyCommandIn); end
        @(negedge clock);
        n_checks++; if (snoopyCommandIn !== 8'h00) begin n_fail++; $display("[TB] FAIL pre_cmd_none1: got %h expected 00", snoopyCommandIn); end
        set_cmd(1, C_INV, 16'h1230);
        @(negedge clock);
        n_checks++; if (snoopyCommandIn !== 8'hF3) begin n_fail++; $display("[TB] FAIL inv_broadcast: got %h expected f3", snoopyCommandIn); end
        n_checks++; if (snoopyAddress !== 16'h1230) begin n_fail++; $display("[TB] FAIL inv_address: got %h expected 1230", snoopyAddress); end
        @(negedge clock); snoopyIsInvalidated = 4'b0001;
        @(negedge clock); snoopyIsInvalidated = 4'b0010;
        @(negedge clock); snoopyIsInvalidated = 4'b0100;
        @(negedge clock);
        n_checks++; if (cpuIsInvalidated !== 4'b0000) begin n_fail++; $display("[TB] FAIL ack_early: got %b expected 0000", cpuIsInvalidated); end
        snoopyIsInvalidated = 4'b1000;
        @(negedge clock);
        n_checks++; if (cpuIsInvalidated !== 4'b0010) begin n_fail++; $display("[TB] FAIL ack_rise: got %b expected 0010", cpuIsInvalidated); end
        snoopyIsInvalidated = 4'b0000;
        @(negedge clock);
        n_checks++; if (cpuIsInvalidated !== 4'b0010) begin n_fail++; $display("[TB] FAIL ack_hold: got %b expected 0010", cpuIsInvalidated); end
    endtask

    task automatic test_bus_read();
        set_cmd(1, C_READ, 16'h2222);
        snoopyIsInvalidated = 4'b1111;
        @(negedge clock);
        n_checks++; if (snoopyCommandIn !== 8'h51) begin n_fail++; $display("[TB] FAIL read_broadcast: got %h expected 51", snoopyCommandIn); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cpuIsInvalidated !== 4'b0000) begin n_fail++; $display("[TB] FAIL read_no_ack: got %b expected 0000", cpuIsInvalidated); end
            @(negedge clock);
        end
        snoopyIsInvalidated = 4'b0000;
    endtask

    task automatic test_round_robin();
        int order[4] = '{2, 3, 0, 1};
        int w;
        request = 4'b0000;
        @(negedge clock);
        n_checks++; if (grant !== 4'b0000 || snoopyCommandIn !== 8'h00 || cpuIsInvalidated !== 4'b0000)
            begin n_fail++; $display("[TB] FAIL release_cycle: got grant=%b cmd=%h inv=%b expected 0000/00/0000", grant, snoopyCommandIn, cpuIsInvalidated); end
        request = 4'b1111;
        foreach (order[j]) begin
            w = 0;
            while (grant === 4'b0000 && w < 10) begin @(negedge clock); w++; end
            n_checks++; if (grant !== (4'b0001 << order[j])) begin n_fail++; $display("[TB] FAIL rr_order%0d: got %b expected owner %0d", j, grant, order[j]); end
            @(negedge clock);
            request[order[j]] = 1'b0;
            @(negedge clock);
            n_checks++; if (grant !== 4'b0000 || snoopyCommandIn !== 8'h00)
                begin n_fail++; $display("[TB] FAIL rr_release%0d: got grant=%b cmd=%h expected 0000/00", j, grant, snoopyCommandIn); end
            request[order[j]] = 1'b1;
        end
    endtask

    task automatic test_command_change();
        int w = 0;
        set_cmd(2, C_RDX, 16'h4444);
        while (grant !== 4'b0100 && w < 10) begin @(negedge clock); w++; end
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("[TB] FAIL chg_grant: got %b expected 0100", grant); end
        @(negedge clock);
        n_checks++; if (snoopyCommandIn !== 8'h8A) begin n_fail++; $display("[TB] FAIL rdx_broadcast: got %h expected 8a", snoopyCommandIn); end
        snoopyIsInvalidated = 4'b0001;
        @(negedge clock); snoopyIsInvalidated = 4'b0010;
        @(negedge clock);
        n_checks++; if (cpuIsInvalidated !== 4'b0000) begin n_fail++; $display("[TB] FAIL chg_partial: got %b expected 0000", cpuIsInvalidated); end
        set_cmd(2, C_INV, 16'h4444);
        snoopyIsInvalidated = 4'b1011;
        @(negedge clock);
        n_checks++; if (cpuIsInvalidated !== 4'b0000) begin n_fail++; $display("[TB] FAIL chg_cleared: got %b expected 0000", cpuIsInvalidated); end
        n_checks++; if (snoopyCommandIn !== 8'hCF) begin n_fail++; $display("[TB] FAIL chg_broadcast: got %h expected cf", snoopyCommandIn); end
        snoopyIsInvalidated = 4'b0001;
        @(negedge clock); snoopyIsInvalidated = 4'b0010;
        @(negedge clock);
        n_checks++; if (cpuIsInvalidated !== 4'b0000) begin n_fail++; $display("[TB] FAIL chg_wait: got %b expected 0000", cpuIsInvalidated); end
        snoopyIsInvalidated = 4'b1000;
        @(negedge clock);
        n_checks++; if (cpuIsInvalidated !== 4'b0100) begin n_fail++; $display("[TB] FAIL chg_ack: got %b expected 0100", cpuIsInvalidated); end
        snoopyIsInvalidated = 4'b0000;
    endtask

    task automatic test_reset_mid_tenure();
        reset = 1'b1;
        @(negedge clock);
        n_checks++; if (grant !== 4'b0000 || snoopyCommandIn !== 8'h00 || cpuIsInvalidated !== 4'b0000)
            begin n_fail++; $display("[TB] FAIL mid_reset: got grant=%b cmd=%h inv=%b expected 0000/00/0000", grant, snoopyCommandIn, cpuIsInvalidated); end
        reset = 1'b0;
        request = 4'b0000;
        @(negedge clock);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("[TB] FAIL post_reset_idle: got %b expected 0000", grant); end
    endtask

    task automatic test_random();
        logic [N-1:0]   eg, ei;
        logic [N*2-1:0] es;
        bit act;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clock);
            act = (m_owner >= 0) && !m_rel;
            eg  = act ? (4'b0001 << m_owner) : 4'b0000;
            es  = '0;
            for (int k = 0; k < N; k++) if (act && k != m_owner) es[k*2 +: 2] = m_cmd;
            ei  = (act && m_done) ? eg : 4'b0000;
            n_checks++; if (grant !== eg) begin n_fail++; $display("[TB] FAIL rand_grant@%0d: got %b expected %b", cyc, grant, eg); end
            n_checks++; if (snoopyCommandIn !== es) begin n_fail++; $display("[TB] FAIL rand_cmd@%0d: got %h expected %h", cyc, snoopyCommandIn, es); end
            n_checks++; if (cpuIsInvalidated !== ei) begin n_fail++; $display("[TB] FAIL rand_inv@%0d: got %b expected %b", cyc, cpuIsInvalidated, ei); end
            if (act) begin
                n_checks++; if (snoopyAddress !== m_addr) begin n_fail++; $display("[TB] FAIL rand_addr@%0d: got %h expected %h", cyc, snoopyAddress, m_addr); end
            end
            reset = ($urandom_range(0, 149) == 0);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 9) == 0) request[k] = ~request[k];
                if ($urandom_range(0, 7) == 0)
                    set_cmd(k, 2'($urandom_range(0, 3)), 16'($urandom));
                snoopyIsInvalidated[k] = ($urandom_range(0, 2) == 0);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        $display("[TB] starting snoopy_bus_controller bench");
        test_reset();
        test_grant_and_invalidate();
        test_bus_read();
        test_round_robin();
        test_command_change();
        test_reset_mid_tenure();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
